// File: rtl/agu_split_unit.sv
// rtl/agu_split_unit.sv - address generation unit with line-crossing split into two aligned beats
module agu_split_unit #(
  parameter int         XLEN     = 32,
  parameter int         TAG_W    = 6,
  parameter int         RD_W     = 7,
  parameter bit         SPLIT_EN = 1'b1,
  parameter logic [3:0] NI_BASE  = 4'hC,
  localparam int        NB       = XLEN / 8,
  localparam int        OFF_W    = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [1:0]       in_size,
  input  logic             in_is_store,
  input  logic             in_unsigned,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [OFF_W-1:0] out_off,
  output logic [NB-1:0]    out_mask,
  output logic [XLEN-1:0]  out_wdata,
  output logic [1:0]       out_size,
  output logic             out_is_store,
  output logic             out_unsigned,
  output logic [RD_W-1:0]  out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_split,
  output logic             out_last,
  output logic             out_exc,
  output logic             out_non_idem
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]        state;
  logic [XLEN-1:0]   f_addr, f_addr0, f_addr1;
  logic [OFF_W-1:0]  f_off;
  logic [3:0]        f_w;
  logic [4:0]        f_end;
  logic              f_cross, f_bad, f_ni0, f_ni1, f_exc, f_split;
  logic [2*NB-1:0]   f_ones, f_mask_w;
  logic [2*XLEN-1:0] f_data_w;
  logic [XLEN-1:0]   b1_addr, b1_wdata;
  logic [NB-1:0]     b1_mask;
  logic              b1_ni;
  logic              accept;

  // Shifting into a double-width vector yields beat0 in the low half and beat1 in the high half.
  always_comb begin
    f_addr  = in_base + in_imm;
    f_off   = f_addr[OFF_W-1:0];
    f_addr0 = f_addr & ~XLEN'(NB - 1);
    f_addr1 = f_addr0 + XLEN'(NB);
    f_w     = 4'd1 << in_size;
    f_end   = 5'(f_off) + 5'(f_w);
    f_cross = f_end > 5'(NB);
    f_bad   = (XLEN == 32) && (in_size == 2'd3);
    f_ni0   = f_addr0[XLEN-1 -: 4] == NI_BASE;
    f_ni1   = f_addr1[XLEN-1 -: 4] == NI_BASE;
    f_exc   = f_bad || (f_cross && (!SPLIT_EN || f_ni0));
    f_split = f_cross && !f_exc;
    case (in_size)
      2'd0:    f_ones = (2*NB)'(8'h01);
      2'd1:    f_ones = (2*NB)'(8'h03);
      2'd2:    f_ones = (2*NB)'(8'h0F);
      default: f_ones = (2*NB)'(8'hFF);
    endcase
    f_mask_w = f_exc ? '0 : (f_ones << f_off);
    f_data_w = f_exc ? '0 : ({{XLEN{1'b0}}, in_wdata} << {f_off, 3'b000});
  end

  assign out_valid = (state != IDLE);
  assign in_ready  = !rst && !flush && ((state == IDLE) || (out_ready && out_last));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_addr     <= '0;
      out_off      <= '0;
      out_mask     <= '0;
      out_wdata    <= '0;
      out_size     <= '0;
      out_is_store <= 1'b0;
      out_unsigned <= 1'b0;
      out_rd       <= '0;
      out_tag      <= '0;
      out_split    <= 1'b0;
      out_last     <= 1'b0;
      out_exc      <= 1'b0;
      out_non_idem <= 1'b0;
      b1_addr      <= '0;
      b1_mask      <= '0;
      b1_wdata     <= '0;
      b1_ni        <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (state == IDLE || out_ready) begin
      if (state == HOLD && out_split && !out_last) begin
        state        <= SECOND;
        out_addr     <= b1_addr;
        out_mask     <= b1_mask;
        out_wdata    <= b1_wdata;
        out_non_idem <= b1_ni;
        out_last     <= 1'b1;
      end else if (accept) begin
        state        <= HOLD;
        out_addr     <= f_addr0;
        out_off      <= f_off;
        out_mask     <= f_mask_w[NB-1:0];
        out_wdata    <= f_data_w[XLEN-1:0];
        out_size     <= in_size;
        out_is_store <= in_is_store;
        out_unsigned <= in_unsigned;
        out_rd       <= in_rd;
        out_tag      <= in_tag;
        out_split    <= f_split;
        out_last     <= !f_split;
        out_exc      <= f_exc;
        out_non_idem <= f_ni0;
        b1_addr      <= f_addr1;
        b1_mask      <= f_mask_w[2*NB-1:NB];
        b1_wdata     <= f_data_w[2*XLEN-1:XLEN];
        b1_ni        <= f_ni1;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_agu_split_unit.sv
// tb/tb_agu_split_unit.sv - scoreboard bench for agu_split_unit (XLEN=32 split, XLEN=64, no-split)
module tb_agu_split_unit;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  off;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic        split;
    logic        last;
    logic        exc;
    logic        ni;
    logic [5:0]  tag;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [63:0] base = '0, imm = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        is_store = 1'b0, uns = 1'b0;
  logic [6:0]  rd = '0;
  logic [5:0]  tag = '0;
  logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic ordy_a = 1'b1, ordy_b = 1'b1, ordy_c = 1'b1;

  int checks = 0, errors = 0;
  beat_t qa[$], qb[$], qc[$];
  beat_t ea, eb, ec;

  always #5 clk = ~clk;

  logic        rdy_a, ov_a, st_a, un_a, sp_a, la_a, ex_a, ni_a;
  logic [31:0] ad_a, wd_a;
  logic [1:0]  of_a, sz_a;
  logic [3:0]  mk_a;
  logic [6:0]  rd_a;
  logic [5:0]  tg_a;

  agu_split_unit #(.XLEN(32), .SPLIT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v_a), .in_ready(rdy_a),
    .in_base(base[31:0]), .in_imm(imm[31:0]), .in_wdata(wdata[31:0]), .in_size(size),
    .in_is_store(is_store), .in_unsigned(uns), .in_rd(rd), .in_tag(tag),
    .out_valid(ov_a), .out_ready(ordy_a), .out_addr(ad_a), .out_off(of_a), .out_mask(mk_a),
    .out_wdata(wd_a), .out_size(sz_a), .out_is_store(st_a), .out_unsigned(un_a), .out_rd(rd_a),
    .out_tag(tg_a), .out_split(sp_a), .out_last(la_a), .out_exc(ex_a), .out_non_idem(ni_a));

  logic        rdy_b, ov_b, st_b, un_b, sp_b, la_b, ex_b, ni_b;
  logic [63:0] ad_b, wd_b;
  logic [2:0]  of_b;
  logic [1:0]  sz_b;
  logic [7:0]  mk_b;
  logic [6:0]  rd_b;
  logic [5:0]  tg_b;

  agu_split_unit #(.XLEN(64), .SPLIT_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v_b), .in_ready(rdy_b),
    .in_base(base), .in_imm(imm), .in_wdata(wdata), .in_size(size),
    .in_is_store(is_store), .in_unsigned(uns), .in_rd(rd), .in_tag(tag),
    .out_valid(ov_b), .out_ready(ordy_b), .out_addr(ad_b), .out_off(of_b), .out_mask(mk_b),
    .out_wdata(wd_b), .out_size(sz_b), .out_is_store(st_b), .out_unsigned(un_b), .out_rd(rd_b),
    .out_tag(tg_b), .out_split(sp_b), .out_last(la_b), .out_exc(ex_b), .out_non_idem(ni_b));

  logic        rdy_c, ov_c, st_c, un_c, sp_c, la_c, ex_c, ni_c;
  logic [31:0] ad_c, wd_c;
  logic [1:0]  of_c, sz_c;
  logic [3:0]  mk_c;
  logic [6:0]  rd_c;
  logic [5:0]  tg_c;

  agu_split_unit #(.XLEN(32), .SPLIT_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v_c), .in_ready(rdy_c),
    .in_base(base[31:0]), .in_imm(imm[31:0]), .in_wdata(wdata[31:0]), .in_size(size),
    .in_is_store(is_store), .in_unsigned(uns), .in_rd(rd), .in_tag(tag),
    .out_valid(ov_c), .out_ready(ordy_c), .out_addr(ad_c), .out_off(of_c), .out_mask(mk_c),
    .out_wdata(wd_c), .out_size(sz_c), .out_is_store(st_c), .out_unsigned(un_c), .out_rd(rd_c),
    .out_tag(tg_c), .out_split(sp_c), .out_last(la_c), .out_exc(ex_c), .out_non_idem(ni_c));

  function automatic beat_t mk(input logic [63:0] a, input logic [2:0] o, input logic [7:0] m,
                               input logic [63:0] w, input logic s, input logic l,
                               input logic e, input logic n, input logic [5:0] t);
    mk = '{addr: a, off: o, mask: m, wdata: w, split: s, last: l, exc: e, ni: n, tag: t};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag %0d: got %h expected %h", nm, exp.tag, act, exp);
    end
  endtask

  // Monitors: one per DUT, popping expected beats on each output handshake.
  always @(negedge clk) begin
    if (!rst && ov_a && ordy_a) begin
      if (qa.size() == 0) chk("dut_a unexpected beat", 64'(ad_a), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        ea = qa.pop_front();
        chk_beat("dut_a beat", mk(64'(ad_a), 3'(of_a), 8'(mk_a), 64'(wd_a), sp_a, la_a, ex_a, ni_a, tg_a), ea);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov_b && ordy_b) begin
      if (qb.size() == 0) chk("dut_b unexpected beat", ad_b, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        eb = qb.pop_front();
        chk_beat("dut_b beat", mk(ad_b, of_b, mk_b, wd_b, sp_b, la_b, ex_b, ni_b, tg_b), eb);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov_c && ordy_c) begin
      if (qc.size() == 0) chk("dut_c unexpected beat", 64'(ad_c), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        ec = qc.pop_front();
        chk_beat("dut_c beat", mk(64'(ad_c), 3'(of_c), 8'(mk_c), 64'(wd_c), sp_c, la_c, ex_c, ni_c, tg_c), ec);
      end
    end
  end

  function automatic logic sel_rdy(input int d);
    sel_rdy = (d == 0) ? rdy_a : (d == 1) ? rdy_b : rdy_c;
  endfunction

  task automatic set_op(input int d, input logic [63:0] b, input logic [63:0] i, input logic [63:0] w,
                        input logic [1:0] s, input logic st, input logic [5:0] t);
    base = b; imm = i; wdata = w; size = s; is_store = st; tag = t; rd = 7'(t); uns = !st;
    v_a = (d == 0); v_b = (d == 1); v_c = (d == 2);
  endtask

  // Presents the op and returns 1 time unit after the accepting clock edge.
  task automatic wait_accept(input int d, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (sel_rdy(d)) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    if (!ok) chk({nm, " accept timeout"}, 64'd0, 64'd1);
  endtask

  task automatic issue(input int d, input logic [63:0] b, input logic [63:0] i, input logic [63:0] w,
                       input logic [1:0] s, input logic st, input logic [5:0] t);
    set_op(d, b, i, w, s, st, t);
    wait_accept(d, "issue");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid a", 64'(ov_a), 64'd0);
    chk("reset in_ready a", 64'(rdy_a), 64'd1);
    chk("reset out_valid b", 64'(ov_b), 64'd0);
    chk("reset in_ready c", 64'(rdy_c), 64'd1);
    @(posedge clk); #1;

    // Aligned-within-word half store.
    qa.push_back(mk(64'h1000, 3'd2, 8'hC, 64'h1234_0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1));
    issue(0, 64'h1000, 64'h2, 64'hABCD_1234, 2'd1, 1'b1, 6'd1);
    @(negedge clk);
    chk("single beat in_ready", 64'(rdy_a), 64'd1);
    @(posedge clk); #1;

    // Crossing word store: two beats, in_ready low during beat0.
    qa.push_back(mk(64'h1000, 3'd3, 8'h8, 64'h4400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2));
    qa.push_back(mk(64'h1004, 3'd3, 8'h7, 64'h0011_2233, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2));
    issue(0, 64'h1000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd2);
    @(negedge clk);
    chk("beat0 in_ready", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;

    // Back-to-back: NI crossing -> exc, aligned load, size3 on XLEN=32, wrap split.
    qa.push_back(mk(64'hC000_0000, 3'd3, 8'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd3));
    issue(0, 64'hC000_0000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd3);
    qa.push_back(mk(64'h2004, 3'd0, 8'hF, 64'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 6'd4));
    issue(0, 64'h2000, 64'h4, 64'hDEAD_BEEF, 2'd2, 1'b0, 6'd4);
    qa.push_back(mk(64'h0100, 3'd0, 8'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5));
    issue(0, 64'h0100, 64'h0, 64'hFFFF_FFFF, 2'd3, 1'b1, 6'd5);
    qa.push_back(mk(64'hFFFF_FFFC, 3'd2, 8'hC, 64'h7788_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd6));
    qa.push_back(mk(64'h0000_0000, 3'd2, 8'h3, 64'h0000_5566, 1'b1, 1'b1, 1'b0, 1'b0, 6'd6));
    issue(0, 64'hFFFF_FFF0, 64'hE, 64'h5566_7788, 2'd2, 1'b1, 6'd6);

    // XLEN=64 dword crossing and aligned dword.
    qb.push_back(mk(64'h08, 3'd7, 8'h80, 64'h0800_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10));
    qb.push_back(mk(64'h10, 3'd7, 8'h7F, 64'h0001_0203_0405_0607, 1'b1, 1'b1, 1'b0, 1'b0, 6'd10));
    issue(1, 64'h08, 64'h7, 64'h0102_0304_0506_0708, 2'd3, 1'b1, 6'd10);
    qb.push_back(mk(64'h20, 3'd0, 8'hFF, 64'h0102_0304_0506_0708, 1'b0, 1'b1, 1'b0, 1'b0, 6'd11));
    issue(1, 64'h20, 64'h0, 64'h0102_0304_0506_0708, 2'd3, 1'b1, 6'd11);

    // SPLIT_EN=0: crossing faults, non-crossing misaligned half is legal.
    qc.push_back(mk(64'h1000, 3'd3, 8'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd20));
    issue(2, 64'h1000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd20);
    qc.push_back(mk(64'h1000, 3'd1, 8'h6, 64'hCD12_3400, 1'b0, 1'b1, 1'b0, 1'b0, 6'd21));
    issue(2, 64'h1000, 64'h1, 64'hABCD_1234, 2'd1, 1'b1, 6'd21);
    repeat (3) @(posedge clk); #1;

    // Stall during split beat0 with the next op waiting.
    ordy_a = 1'b0;
    qa.push_back(mk(64'h1000, 3'd3, 8'h8, 64'h4400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd7));
    qa.push_back(mk(64'h1004, 3'd3, 8'h7, 64'h0011_2233, 1'b1, 1'b1, 1'b0, 1'b0, 6'd7));
    qa.push_back(mk(64'h3000, 3'd0, 8'hF, 64'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8));
    issue(0, 64'h1000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd7);
    set_op(0, 64'h3000, 64'h0, 64'hCAFE_F00D, 2'd2, 1'b1, 6'd8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall out_valid", 64'(ov_a), 64'd1);
      chk("stall addr", 64'(ad_a), 64'h1000);
      chk("stall wdata", 64'(wd_a), 64'h4400_0000);
      chk("stall in_ready", 64'(rdy_a), 64'd0);
    end
    @(posedge clk); #1;
    ordy_a = 1'b1;
    wait_accept(0, "after stall");
    repeat (2) @(posedge clk); #1;

    // Flush while in SECOND with a new op presented.
    qa.push_back(mk(64'h1000, 3'd3, 8'h8, 64'h4400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9));
    issue(0, 64'h1000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd9);
    @(posedge clk); #1;
    ordy_a = 1'b0;
    set_op(0, 64'h4000, 64'h0, 64'h1, 2'd2, 1'b1, 6'd12);
    flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; v_a = 1'b0; ordy_a = 1'b1;
    @(negedge clk);
    chk("flush out_valid", 64'(ov_a), 64'd0);
    chk("flush in_ready after", 64'(rdy_a), 64'd1);
    @(negedge clk);
    chk("flush op dropped", 64'(ov_a), 64'd0);
    @(posedge clk); #1;

    // Reset mid-split.
    qa.push_back(mk(64'h1000, 3'd3, 8'h8, 64'h4400_0000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd13));
    issue(0, 64'h1000, 64'h3, 64'h1122_3344, 2'd2, 1'b1, 6'd13);
    @(posedge clk); #1;
    ordy_a = 1'b0;
    set_op(0, 64'h4000, 64'h0, 64'h1, 2'd2, 1'b1, 6'd14);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v_a = 1'b0; ordy_a = 1'b1;
    @(negedge clk);
    chk("rst out_valid", 64'(ov_a), 64'd0);
    chk("rst out_addr", 64'(ad_a), 64'd0);
    chk("rst out_mask", 64'(mk_a), 64'd0);
    chk("rst in_ready", 64'(rdy_a), 64'd1);
    repeat (3) @(posedge clk); #1;

    chk("dut_a queue drained", 64'(qa.size()), 64'd0);
    chk("dut_b queue drained", 64'(qb.size()), 64'd0);
    chk("dut_c queue drained", 64'(qc.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
